// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches sequential words ahead of the consumer into a {pc, inst} FIFO.
// Optional PREFETCH_STATS_EN adds a saturating stat_discards counter of words thrown away by flushes.
module inst_prefetch #(
    parameter int M_WIDTH    = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter logic [M_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [M_WIDTH-1:0]    flush_pc,
    output logic                  mem_req,
    output logic [M_WIDTH-1:0]    mem_addr,
    input  logic                  mem_ready,
    input  logic [M_WIDTH-1:0]    mem_data_in,
    output logic                  valid,
    input  logic                  pop,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [M_WIDTH-1:0]    pc_out
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]           stat_discards
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [M_WIDTH-1:0] WORD_BYTES = M_WIDTH'(M_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t                state;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [M_WIDTH-1:0]    fetch_pc;
    logic [M_WIDTH-1:0]    pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic                  push;
    logic                  do_pop;

    assign push   = (state == REQ) && mem_ready && !flush;
    assign do_pop = pop && valid && !flush;

    assign valid    = (count != '0);
    assign inst_out = valid ? inst_mem[rd_ptr] : '0;
    assign pc_out   = valid ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            if (flush) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= flush_pc;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + AW'(1);
                    fetch_pc <= fetch_pc + WORD_BYTES;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !do_pop) begin
                    count <= count + CW'(1);
                end else if (do_pop && !push) begin
                    count <= count - CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (!flush && (count < CW'(DEPTH))) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A response always retires the stale request, even if another flush lands with it.
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [16:0] discard_sum;

    // Words lost on a flush: everything queued plus a live (not already drained) request.
    assign discard_sum = {1'b0, stat_discards} + 17'(count) + 17'(state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_discards <= '0;
        end else if (flush) begin
            stat_discards <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized scoreboard bench for inst_prefetch against a queue-based reference model.
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data_in;
    logic        valid;
    logic        pop;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_discards;
`endif

    always #5 clk = ~clk;

    inst_prefetch #(
        .M_WIDTH   (32),
        .INST_WIDTH(32),
        .DEPTH     (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data_in(mem_data_in),
        .valid      (valid),
        .pop        (pop),
        .inst_out   (inst_out),
        .pc_out     (pc_out)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_discards(stat_discards)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        expq[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: next sequential address, outstanding request, and whether it was flushed.
    logic [31:0] next_pc = 32'h0;
    logic [31:0] req_addr = 32'h0;
    bit          busy = 1'b0;
    bit          stale = 1'b0;
    int          lat = 0;
    int          disc = 0;
    bit          rst_prev = 1'b1;

    int pop_pct, flush_pct, rst_pm, lat_max, spur_pct;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Driver plus memory responder; pushes expected entries when a live response is accepted.
    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0; pop = 1'b0;
        mem_ready = 1'b0; mem_data_in = '0;
        pop_pct = 0; flush_pct = 0; rst_pm = 0; lat_max = 0; spur_pct = 0;
        for (int cyc = 0; cyc < 3600; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc >= 40 && (cyc % 400) == 40) begin
                case ((cyc / 400) % 3)
                    0: pop_pct = 20;
                    1: pop_pct = 55;
                    default: pop_pct = 90;
                endcase
                flush_pct = 6; rst_pm = 3; lat_max = 3; spur_pct = 10;
            end
            rst   = (cyc < 3) || ($urandom_range(0, 999) < rst_pm);
            pop   = ($urandom_range(0, 99) < pop_pct);
            flush = ($urandom_range(0, 99) < flush_pct);
            flush_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom(), 2'b00};
            mem_ready   = 1'b0;
            mem_data_in = $urandom();
            if (!busy && mem_req) begin
                busy     = 1'b1;
                req_addr = mem_addr;
                lat      = $urandom_range(0, lat_max);
                chk("req_addr", mem_addr, next_pc);
            end
            if (busy) begin
                chk("req_hold", 32'(mem_req), 32'd1);
                chk("addr_hold", mem_addr, req_addr);
                if (lat == 0) mem_ready = 1'b1;
                else lat--;
            end else if ($urandom_range(0, 99) < spur_pct) begin
                mem_ready = 1'b1;
            end

            @(posedge clk);
            if (rst) begin
                expq.delete();
                next_pc = 32'h0;
                busy = 1'b0; stale = 1'b0; disc = 0;
            end else if (flush) begin
                disc += expq.size() + ((busy && !stale) ? 1 : 0);
                if (disc > 65535) disc = 65535;
                expq.delete();
                next_pc = flush_pc;
                if (busy && mem_ready) begin
                    busy = 1'b0; stale = 1'b0;
                end else if (busy) begin
                    stale = 1'b1;
                end
            end else if (busy && mem_ready) begin
                if (!stale) begin
                    expq.push_back('{pc: req_addr, inst: mem_data_in});
                    next_pc += 32'd4;
                end
                busy = 1'b0; stale = 1'b0;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: compares the presented head against the scoreboard and retires accepted pops.
    initial begin
        int sz;
        forever begin
            @(negedge clk);
            sz = expq.size();
            chk("valid", 32'(valid), 32'(sz != 0));
            if (sz != 0) begin
                chk("pc_out", pc_out, expq[0].pc);
                chk("inst_out", inst_out, expq[0].inst);
            end else begin
                chk("pc_zero", pc_out, 32'h0);
                chk("inst_zero", inst_out, 32'h0);
            end
            if (rst_prev) begin
                chk("rst_req", 32'(mem_req), 32'd0);
                chk("rst_addr", mem_addr, 32'h0);
            end
            if (sz == 4 && !busy) chk("full_no_req", 32'(mem_req), 32'd0);
`ifdef PREFETCH_STATS_EN
            chk("stat_discards", 32'(stat_discards), 32'(disc));
`endif
            @(posedge clk);
            rst_prev = rst;
            if (!rst && !flush && pop && sz != 0) void'(expq.pop_front());
        end
    end

endmodule
